pmem_arbiter: RTL

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/pmem_arbiter_pkg.sv | 20 ++
 rtl/pmem_arbiter_if.sv | 40 ++++
 rtl/pmem_arbiter_rr_picker.sv | 29 ++
 rtl/pmem_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types and helpers for the physical-memory arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pmem_arbiter_pkg;

  // Arbiter FSM: IDLE picks a winner, BUSY forwards it until pmem_resp.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 4;

  // Width of a port index, i.e. $clog2(NUM_PORTS), never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of master-side request/response and downstream pmem signals.
// Latency: n/a (wiring only).
// Backpressure: masters hold requests until their m_resp pulse.
interface pmem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic [NUM_PORTS-1:0]                   m_read;
  logic [NUM_PORTS-1:0]                   m_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   m_address;
  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]   m_wdata;
  logic [NUM_PORTS-1:0][LINE_WIDTH/8-1:0] m_byte_enable;
  logic [NUM_PORTS-1:0]                   m_resp;
  logic [LINE_WIDTH-1:0]                  m_rdata;

  logic                    pmem_read;
  logic                    pmem_write;
  logic [ADDR_WIDTH-1:0]   pmem_address;
  logic [LINE_WIDTH-1:0]   pmem_wdata;
  logic [LINE_WIDTH/8-1:0] pmem_byte_enable;
  logic                    pmem_resp;
  logic [LINE_WIDTH-1:0]   pmem_rdata;

  // Arbiter side.
  modport slave (
    input  m_read, m_write, m_address, m_wdata, m_byte_enable,
    output m_resp, m_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    input  pmem_resp, pmem_rdata
  );

  // Environment side: masters plus memory.
  modport master (
    output m_read, m_write, m_address, m_wdata, m_byte_enable,
    input  m_resp, m_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_arbiter_rr_picker.sv
// Round-robin picker: first set req bit searching upward from ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; vld low when no request is present.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             vld
);

  // Scan offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    int w_idx;
    w_idx = 0;
    gnt   = '0;
    vld   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = (int'(ptr) + i) % N;
      if (req[w_idx]) begin
        gnt = IDX_W'(w_idx);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter of NUM_PORTS line masters onto one physical-memory port.
// Latency: downstream request one cycle after a request is seen in IDLE; m_resp same cycle as pmem_resp.
// Backpressure: one transaction in flight; other masters hold requests until granted.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic            clk,
  input logic            rst,
  pmem_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int BE_W  = LINE_WIDTH / 8;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
  } req_t;

  state_e           r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_rr_ptr;
  req_t             r_req;

  logic [NUM_PORTS-1:0] w_cand;
  logic [IDX_W-1:0]     w_pick;
  logic                 w_pick_vld;
  req_t                 w_pick_req;
  req_t                 w_gnt_req;
  req_t                 w_out;
  logic                 w_gnt_live;
  logic                 w_busy;
  logic                 w_done;
  logic [NUM_PORTS-1:0] w_resp;

  assign w_cand = bus.m_read | bus.m_write;

  rr_picker #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
    .req (w_cand),
    .ptr (r_rr_ptr),
    .gnt (w_pick),
    .vld (w_pick_vld)
  );

  // Request of the port the picker would choose this cycle (latched on grant).
  always_comb begin
    w_pick_req       = '0;
    w_pick_req.rd    = bus.m_read[w_pick];
    w_pick_req.wr    = bus.m_write[w_pick];
    w_pick_req.addr  = bus.m_address[w_pick];
    w_pick_req.wdata = bus.m_wdata[w_pick];
    w_pick_req.be    = bus.m_byte_enable[w_pick];
  end

  // Live request of the currently granted port.
  always_comb begin
    w_gnt_req       = '0;
    w_gnt_req.rd    = bus.m_read[r_grant];
    w_gnt_req.wr    = bus.m_write[r_grant];
    w_gnt_req.addr  = bus.m_address[r_grant];
    w_gnt_req.wdata = bus.m_wdata[r_grant];
    w_gnt_req.be    = bus.m_byte_enable[r_grant];
  end

  // Follow the granted master live; if it drops mid-transaction, replay the
  // last latched copy so the downstream request stays stable until pmem_resp.
  assign w_gnt_live = w_gnt_req.rd | w_gnt_req.wr;
  assign w_out      = w_gnt_live ? w_gnt_req : r_req;
  assign w_busy     = (r_state == ST_BUSY);
  assign w_done     = w_busy & bus.pmem_resp & ~rst;

  // A write wins over a simultaneous read from the same master.
  assign bus.pmem_read        = w_busy & w_out.rd & ~w_out.wr;
  assign bus.pmem_write       = w_busy & w_out.wr;
  assign bus.pmem_address     = w_out.addr;
  assign bus.pmem_wdata       = w_out.wdata;
  assign bus.pmem_byte_enable = w_out.be;
  assign bus.m_rdata          = bus.pmem_rdata;

  // Completion pulse goes only to the granted master, and only while BUSY.
  always_comb begin
    w_resp = '0;
    if (w_done) begin
      w_resp[r_grant] = 1'b1;
    end
  end
  assign bus.m_resp = w_resp;

  // FSM, grant/pointer bookkeeping and the single latched request copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_req    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant <= w_pick;
            r_req   <= w_pick_req;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_gnt_live) begin
            r_req <= w_gnt_req;
          end
          if (bus.pmem_resp) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= (r_grant == IDX_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
